// File: rtl/mem_block_mover.sv
// Command-driven fill/copy engine in front of a single-port memory bank.
// Fill: done at L+2; copy: done at 2L+2; start is only sampled when idle.
module mem_block_mover #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] read_data
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_FILL    = 3'd2;
    localparam logic [2:0] S_COPY_RD = 3'd3;
    localparam logic [2:0] S_COPY_WR = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        state;
    logic              op_r;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [ADDR_W:0]   len_r;
    logic [DATA_W-1:0] fill_r;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   rem;
    logic              desc_r;
    logic              err_r;

    // Copying towards higher addresses walks backwards so overlapping source bytes are read before being overwritten.
    logic              is_desc;
    logic [ADDR_W-1:0] idx_step;
    logic              last_byte;

    assign is_desc   = !op_r && (dst_r > src_r);
    assign idx_step  = desc_r ? idx - IDX_ONE : idx + IDX_ONE;
    assign last_byte = (rem == LEN_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_r   <= 1'b0;
            src_r  <= '0;
            dst_r  <= '0;
            len_r  <= '0;
            fill_r <= '0;
            idx    <= '0;
            rem    <= '0;
            desc_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r   <= op;
                        src_r  <= src_addr;
                        dst_r  <= dst_addr;
                        len_r  <= length;
                        fill_r <= fill_value;
                        err_r  <= 1'b0;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (len_r > DEPTH) begin
                        err_r <= 1'b1;
                        state <= S_DONE;
                    end else if (len_r == '0) begin
                        state <= S_DONE;
                    end else begin
                        desc_r <= is_desc;
                        idx    <= is_desc ? len_r[ADDR_W-1:0] - IDX_ONE : '0;
                        rem    <= len_r;
                        state  <= op_r ? S_FILL : S_COPY_RD;
                    end
                end
                S_FILL: begin
                    if (last_byte) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx_step;
                        rem <= rem - LEN_ONE;
                    end
                end
                S_COPY_RD: state <= S_COPY_WR;
                S_COPY_WR: begin
                    if (last_byte) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx_step;
                        rem   <= rem - LEN_ONE;
                        state <= S_COPY_RD;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        err        = (state == S_DONE) && err_r;
        address    = '0;
        write_data = '0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        case (state)
            S_FILL: begin
                mem_write  = 1'b1;
                address    = dst_r + idx;
                write_data = fill_r;
            end
            S_COPY_RD: begin
                mem_read = 1'b1;
                address  = src_r + idx;
            end
            S_COPY_WR: begin
                mem_write  = 1'b1;
                address    = dst_r + idx;
                write_data = read_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: behavioural bank plus a byte-order reference model.
module tb_mem_block_mover;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [7:0] src_addr = '0;
    logic [7:0] dst_addr = '0;
    logic [8:0] length = '0;
    logic [7:0] fill_value = '0;
    logic       busy, done, err, mem_write, mem_read;
    logic [7:0] address, write_data;
    logic [7:0] read_data = '0;

    always #5 clk = ~clk;

    mem_block_mover #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_value(fill_value), .busy(busy), .done(done), .err(err),
        .address(address), .write_data(write_data),
        .mem_write(mem_write), .mem_read(mem_read), .read_data(read_data)
    );

    logic [7:0] bank [256];
    logic [7:0] ref_mem [256];

    always @(posedge clk) begin
        if (mem_read)  read_data <= bank[address];
        if (mem_write) bank[address] <= write_data;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic preload(input int a, input logic [7:0] v);
        bank[a & 255]    = v;
        ref_mem[a & 255] = v;
    endtask

    // Runs one command; rst_at >= 0 asserts reset so it is sampled at the end of that cycle.
    task automatic run_cmd(input logic o, input int s, input int d, input int l,
                           input int f, input bit noise, input int rst_at);
        int wa[$];
        int ra[$];
        int n, off, last, exp_done_cyc, tmp, cyc, done_cyc, n_wr, n_rd, excl, busy_bad;
        int bad_addr, bad_data, n_done, got_err, mis;
        bit desc, exp_err;
        exp_err = (l > 256);
        n       = exp_err ? 0 : l;
        desc    = !o && (d > s);
        last    = (rst_at >= 0) ? rst_at : 1 << 30;
        for (int k = 0; k < n; k++) begin
            off = o ? k : (desc ? n - 1 - k : k);
            if (o) begin
                if (2 + k <= last) begin
                    wa.push_back((d + off) & 255);
                    ref_mem[(d + off) & 255] = f[7:0];
                end
            end else begin
                if (2 + 2*k <= last) begin
                    ra.push_back((s + off) & 255);
                    tmp = ref_mem[(s + off) & 255];
                    if (3 + 2*k <= last) begin
                        wa.push_back((d + off) & 255);
                        ref_mem[(d + off) & 255] = tmp[7:0];
                    end
                end
            end
        end
        exp_done_cyc = (n == 0) ? 2 : (o ? n + 2 : 2*n + 2);

        start = 1'b1; op = o; src_addr = s[7:0]; dst_addr = d[7:0];
        length = l[8:0]; fill_value = f[7:0];
        @(posedge clk); #1;
        start = 1'b0;
        n_wr = 0; n_rd = 0; excl = 0; busy_bad = 0; bad_addr = 0; bad_data = 0;
        n_done = 0; done_cyc = -1; got_err = 0;
        for (cyc = 1; cyc < 700; cyc++) begin
            if (noise) begin
                start = $urandom_range(0, 1); op = $urandom_range(0, 1);
                src_addr = $urandom; dst_addr = $urandom;
                length = $urandom_range(1, 8); fill_value = $urandom;
            end
            @(negedge clk);
            if (mem_read && mem_write) excl++;
            if (!busy) busy_bad++;
            if (mem_write) begin
                n_wr++;
                if (wa.size() == 0) bad_addr++;
                else if (int'(address) != wa.pop_front()) bad_addr++;
                if (o && write_data != f[7:0]) bad_data++;
            end
            if (mem_read) begin
                n_rd++;
                if (ra.size() == 0) bad_addr++;
                else if (int'(address) != ra.pop_front()) bad_addr++;
            end
            if (done) begin
                n_done++; done_cyc = cyc; got_err = int'(err);
                start = 1'b0;
            end
            if (cyc == rst_at) rst = 1'b1;
            @(posedge clk); #1;
            if (cyc == rst_at) begin
                rst = 1'b0;
                @(negedge clk);
                check("rst_busy", int'(busy), 0);
                check("rst_strobes", int'(mem_read) + int'(mem_write), 0);
                check("rst_done", int'(done), 0);
                break;
            end
            if (done_cyc > 0) break;
        end
        start = 1'b0;
        if (rst_at < 0) begin
            check("done_cycle", done_cyc, exp_done_cyc);
            check("err", got_err, int'(exp_err));
            check("busy_high", busy_bad, 0);
            @(negedge clk);
            check("idle_after", int'(busy) + int'(done), 0);
        end else begin
            check("no_done", n_done, 0);
        end
        check("excl", excl, 0);
        check("seq_addr", bad_addr, 0);
        check("fill_data", bad_data, 0);
        check("leftover", wa.size() + ra.size(), 0);
        mis = 0;
        for (int a = 0; a < 256; a++) if (bank[a] !== ref_mem[a]) mis++;
        check("mem", mis, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) preload(a, 8'($urandom));
        rst = 1'b1; start = 1'b1; length = 9'd4; op = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outs", int'({busy, done, err, mem_write, mem_read}), 0);
        check("reset_addr", int'(address) + int'(write_data), 0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        run_cmd(1'b1, 0, 8'h10, 4, 8'hA5, 1'b0, -1);
        preload(8'h20, 8'd11); preload(8'h21, 8'd22); preload(8'h22, 8'd33);
        run_cmd(1'b0, 8'h20, 8'h80, 3, 0, 1'b0, -1);
        check("copy_80", int'(bank[8'h80]) * 65536 + int'(bank[8'h81]) * 256 + int'(bank[8'h82]),
              11 * 65536 + 22 * 256 + 33);
        for (int i = 0; i < 4; i++) preload(8'h40 + i, 8'(i + 1));
        run_cmd(1'b0, 8'h40, 8'h42, 4, 0, 1'b0, -1);
        check("overlap", int'({bank[8'h42], bank[8'h43], bank[8'h44], bank[8'h45]}), 32'h01020304);
        run_cmd(1'b1, 0, 8'hFE, 4, 8'h5A, 1'b0, -1);
        run_cmd(1'b1, 0, 8'h37, 256, 8'hC3, 1'b0, -1);
        run_cmd(1'b0, 8'h10, 8'h90, 0, 0, 1'b0, -1);
        run_cmd(1'b1, 0, 8'h90, 300, 8'h77, 1'b0, -1);
        run_cmd(1'b0, 8'h05, 8'h60, 6, 0, 1'b1, -1);
        run_cmd(1'b0, 8'h30, 8'hB0, 5, 0, 1'b0, 6);
        run_cmd(1'b1, 0, 8'hB0, 3, 8'h99, 1'b0, -1);

        // Reset must beat a simultaneous start.
        rst = 1'b1; start = 1'b1; length = 9'd2; op = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_vs_start", int'(busy), 0);
        @(posedge clk); #1;

        for (int t = 0; t < 30; t++) begin
            int l, s, d;
            case ($urandom_range(0, 9))
                0:       l = 256;
                1:       l = $urandom_range(257, 511);
                2:       l = 0;
                default: l = $urandom_range(1, 40);
            endcase
            s = $urandom_range(0, 255);
            d = ($urandom_range(0, 2) == 0) ? ((s + $urandom_range(0, 8) - 4) & 255) : $urandom_range(0, 255);
            run_cmd(1'($urandom_range(0, 1)), s, d, l, $urandom_range(0, 255),
                    1'($urandom_range(0, 1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
